// File: rtl/ws2812_strip.sv
// WS2812 LED strip driver: NUM_LEDS x 24-bit pixel buffer serialised as GRB, MSB first.
// Define WS2812_BRIGHTNESS_EN to scale every channel by (brightness + 1) / 256 at pixel fetch.
module ws2812_strip #(
    parameter int unsigned NUM_LEDS    = 10,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned T0H         = 20,
    parameter int unsigned T0L         = 42,
    parameter int unsigned T1H         = 40,
    parameter int unsigned T1L         = 22,
    parameter int unsigned RESET_TICKS = 3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        brightness,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              dataline
);

    localparam int unsigned MAX_T01 = (T0H > T0L) ? T0H : T0L;
    localparam int unsigned MAX_T1  = (T1H > T1L) ? T1H : T1L;
    localparam int unsigned MAX_TB  = (MAX_T01 > MAX_T1) ? MAX_T01 : MAX_T1;
    localparam int unsigned MAX_T   = (MAX_TB > RESET_TICKS) ? MAX_TB : RESET_TICKS;
    localparam int unsigned CNT_W   = $clog2(MAX_T + 1);
    localparam int unsigned IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_done;
    logic [CNT_W-1:0]    r_cnt;
    logic [23:0]         r_shift;
    logic [4:0]          r_bitcnt;
    logic [ADDR_W-1:0]   r_pixidx;
    logic [23:0]         r_pix [NUM_LEDS];

    logic                w_cnt_zero;
    logic                w_last_bit;
    logic [ADDR_W-1:0]   w_fetch_idx;
    logic [23:0]         w_fetch_rgb;
    logic [23:0]         w_fetch;

    function automatic logic [CNT_W-1:0] hi_time(input logic b);
        return b ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
    endfunction

    function automatic logic [CNT_W-1:0] lo_time(input logic b);
        return b ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
    endfunction

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_last_bit  = (r_bitcnt == 5'd23) && (r_pixidx == LAST_IDX);
    assign w_fetch_idx = (r_state == S_LOAD) ? '0 : r_pixidx + ADDR_W'(1);

    // A write landing on the fetch edge is forwarded so it is the value transmitted.
    assign w_fetch_rgb = (wr_en && wr_addr == w_fetch_idx) ? wr_data
                                                           : r_pix[w_fetch_idx[IDX_W-1:0]];

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        return 8'((16'(c) * (16'(br) + 16'd1)) >> 8);
    endfunction

    assign w_fetch = {scale(w_fetch_rgb[15:8], brightness),
                      scale(w_fetch_rgb[23:16], brightness),
                      scale(w_fetch_rgb[7:0], brightness)};
`else
    logic w_unused;
    assign w_unused = ^brightness;
    assign w_fetch  = {w_fetch_rgb[15:8], w_fetch_rgb[23:16], w_fetch_rgb[7:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) r_pix[i] <= '0;
        end else if (wr_en && wr_addr <= LAST_IDX) begin
            r_pix[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= (r_state == S_LATCH) && w_cnt_zero;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (start && !r_done) w_state_nx = S_LOAD;
            S_LOAD:  w_state_nx = S_HIGH;
            S_HIGH:  if (w_cnt_zero) w_state_nx = S_LOW;
            S_LOW:   if (w_cnt_zero) w_state_nx = w_last_bit ? S_LATCH : S_HIGH;
            S_LATCH: if (w_cnt_zero) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = r_done;
        dataline = (r_state == S_HIGH);
    end

    // Pixel k+1 is fetched on the closing edge of pixel k's last low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_pixidx <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shift  <= w_fetch;
                    r_bitcnt <= '0;
                    r_pixidx <= '0;
                    r_cnt    <= hi_time(w_fetch[23]);
                end
                S_HIGH: begin
                    r_cnt <= w_cnt_zero ? lo_time(r_shift[23]) : r_cnt - CNT_W'(1);
                end
                S_LOW: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_bitcnt == 5'd23) begin
                        if (r_pixidx == LAST_IDX) begin
                            r_cnt <= CNT_W'(RESET_TICKS - 1);
                        end else begin
                            r_pixidx <= w_fetch_idx;
                            r_bitcnt <= '0;
                            r_shift  <= w_fetch;
                            r_cnt    <= hi_time(w_fetch[23]);
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + 5'd1;
                        r_shift  <= {r_shift[22:0], 1'b0};
                        r_cnt    <= hi_time(r_shift[22]);
                    end
                end
                S_LATCH: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_strip.sv
// Directed bench for ws2812_strip with default timing and NUM_LEDS=10.
module tb_ws2812_strip;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic [7:0]  brightness;
    logic        start;
    logic        busy;
    logic        done;
    logic        dataline;

    int checks;
    int passed;
    int failed;

    ws2812_strip #(
        .NUM_LEDS(10),
        .ADDR_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .brightness(brightness),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .dataline  (dataline)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic get_bit(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (dataline === 1'b1 && hi < 1000) begin
            hi++;
            tick;
        end
        while (dataline !== 1'b1 && lo < 1000) begin
            lo++;
            tick;
        end
    endtask

    task automatic get_byte(output logic [7:0] val, output int bad);
        int hi;
        int lo;
        val = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            get_bit(hi, lo);
            val = {val[6:0], 1'(hi == 40)};
            if (!((hi == 20 && lo == 42) || (hi == 40 && lo == 22))) bad++;
        end
    endtask

    logic [7:0] g_val, r_val, b_val;
    logic [7:0] exp_g;
    int         g_bad, r_bad, b_bad;
    int         n, runs, bad_runs, run_len, busy_drop;
    logic       prev;

    initial begin
        checks = 0;
        passed = 0;
        failed = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        brightness = 8'h7F;
        start = 1'b0;
        repeat (3) tick;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_line", dataline, 0);
        rst_n = 1'b1;
        tick;

        // Pixel 0 = 0xFF000F: G=00, R=FF, B=0F
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 24'hFF000F;
        tick;
        wr_en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_line", dataline, 0);
        tick;
        check("e1_line", dataline, 1);
        get_byte(g_val, g_bad);
        get_byte(r_val, r_bad);
        get_byte(b_val, b_bad);
        check("p0_g", 32'(g_val), 32'h00);
        check("p0_g_timing", g_bad, 0);
        check("p0_r", 32'(r_val), 32'hFF);
        check("p0_r_timing", r_bad, 0);
        check("p0_b", 32'(b_val), 32'h0F);
        check("p0_b_timing", b_bad, 0);

        // Asynchronous reset in the middle of pixel 1's first high phase
        check("p1_high", dataline, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_line", dataline, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;

        // Start coinciding with a write to pixel 0
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 24'h00FF00; start = 1'b1;
        tick;
        wr_en = 1'b0; start = 1'b0;
        check("coinc_busy", busy, 1);
        tick;
        check("coinc_e1_line", dataline, 1);
        get_byte(g_val, g_bad);
        get_byte(r_val, r_bad);
`ifdef WS2812_BRIGHTNESS_EN
        exp_g = 8'h7F;
`else
        exp_g = 8'hFF;
`endif
        check("coinc_g", 32'(g_val), 32'(exp_g));
        check("coinc_g_timing", g_bad, 0);
        check("coinc_r", 32'(r_val), 32'h00);
        check("coinc_b_high", dataline, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst2_line", dataline, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // Out-of-range write, then a full all-zero frame with ignored starts
        wr_en = 1'b1; wr_addr = 8'd10; wr_data = 24'hFFFFFF;
        tick;
        wr_en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("frame_busy", busy, 1);
        n = 0; runs = 0; bad_runs = 0; run_len = 0; busy_drop = 0; prev = 1'b0;
        while (done !== 1'b1 && n < 20000) begin
            if (n == 5000) start = 1'b1;
            tick;
            n++;
            start = 1'b0;
            if (dataline === 1'b1) begin
                run_len++;
            end else if (prev) begin
                runs++;
                if (run_len != 20) bad_runs++;
                run_len = 0;
            end
            prev = dataline;
            if (done !== 1'b1 && busy !== 1'b1) busy_drop++;
        end
        check("frame_done_latency", n, 17881);
        check("frame_done_busy", busy, 0);
        check("frame_bit_count", runs, 240);
        check("frame_zero_bits", bad_runs, 0);
        check("frame_busy_hold", busy_drop, 0);

        // Start on the done cycle is ignored
        start = 1'b1;
        tick;
        start = 1'b0;
        check("done_start_busy", busy, 0);
        check("done_pulse_width", done, 0);
        repeat (3) tick;
        check("idle_busy", busy, 0);
        check("idle_line", dataline, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_strip.md
WS2812_STRIP -- requirements
Module: ws2812_strip

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 10: pixels per frame, range 1..256.
REQ-002 SHALL have parameter ADDR_W, default 8: width of wr_addr; must satisfy 2^ADDR_W >= NUM_LEDS.
REQ-003 SHALL have parameters T0H / T0L / T1H / T1L, defaults 20 / 42 / 40 / 22: clk cycles high/low for a 0-bit and a 1-bit.
REQ-004 SHALL have parameter RESET_TICKS, default 3000: clk cycles of low latch time after the last bit.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port wr_en, input, 1: pixel buffer write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W: pixel index to write.
REQ-009 SHALL have port wr_data, input, 24: pixel color {r[23:16], g[15:8], b[7:0]}.
REQ-010 SHALL have port brightness, input, 8: global scale; used only under the macro in REQ-027.
REQ-011 SHALL have port start, input, 1: one-cycle frame request.
REQ-012 SHALL have port busy, output, 1: frame in progress.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at end of frame.
REQ-014 SHALL have port dataline, output, 1: serial line to the strip.

Function
REQ-015 SHALL hold a NUM_LEDS x 24-bit pixel buffer; wr_en with wr_addr < NUM_LEDS writes wr_data at that edge in any state; wr_addr >= NUM_LEDS is ignored.
REQ-016 SHALL implement states IDLE -> LOAD -> HIGH <-> LOW -> LATCH -> IDLE.
REQ-017 SHALL move IDLE -> LOAD on start at edge E0, setting busy=1 after E0; LOAD fetches pixel 0 and lasts exactly 1 cycle; dataline=1 after E1.
REQ-018 SHALL transmit per pixel G[7:0], R[7:0], B[7:0], each MSB first; pixels in order 0..NUM_LEDS-1.
REQ-019 SHALL drive each bit high for exactly T1H (1-bit) or T0H (0-bit) cycles, then low for T1L or T0L cycles, with no gap cycles between bits or pixels.
REQ-020 SHALL fetch pixel k+1 during pixel k; a write to pixel j applied no later than the edge on which pixel j is fetched is transmitted.
REQ-021 SHALL enter LATCH after the last bit's low phase, hold dataline=0 for RESET_TICKS cycles, then assert done=1 for one cycle with busy=0 on the same cycle and return to IDLE.
REQ-022 SHALL therefore assert done at edge E0 + 1 + (sum of bit periods) + RESET_TICKS.
REQ-023 SHALL ignore start while busy=1, including on the cycle done=1.
REQ-024 SHALL, when start and wr_en to pixel 0 coincide in IDLE, transmit the newly written pixel 0.
REQ-025 SHALL hold dataline=0 in IDLE, LOAD and LATCH.

Reset
REQ-026 SHALL, on rst_n low (asynchronous, including mid-frame), immediately force state=IDLE, dataline=0, busy=0 and done=0, clear counters, and clear all pixel buffer entries to 0; the frame in progress is abandoned.

Configuration
REQ-027 SHALL, with WS2812_BRIGHTNESS_EN defined, transmit each channel c as (c * (brightness + 1)) >> 8, 8-bit result, sampled at pixel fetch; without it, transmit channels unscaled, ignore the brightness port and instantiate no multiplier.

Verification
REQ-028 SHALL cover: NUM_LEDS=2, pixel0=0xFF000F, start -> G byte is eight 0-bits (20 high / 42 low), R byte is eight 1-bits (40 / 22), B byte is 0000_1111.
REQ-029 SHALL cover: NUM_LEDS=10, buffer all zero, start at E0 -> done at E0+17881 (1+240*62+3000); busy high throughout and low on the done cycle.
REQ-030 SHALL cover: start pulsed mid-frame and on the done cycle -> no second frame; wr_addr=NUM_LEDS with wr_data=0xFFFFFF -> no buffer change.
REQ-031 SHALL cover: rst_n low during a bit's high phase -> dataline 0 without waiting for a clk edge, busy 0; a later start transmits all-zero pixels.
REQ-032 SHALL cover: WS2812_BRIGHTNESS_EN defined, brightness=0x7F, pixel=0x00FF00 -> G transmitted as 0x7F; macro undefined -> 0xFF.
REQ-033 SHALL cover: start and wr_en(addr 0, 0x00FF00) on the same edge -> first transmitted byte is G=0xFF.
